// File: rtl/traffic_ctrl_param.sv
// Parametrised 2..4 approach traffic-signal controller with demand-based approach skipping.
// Optional pedestrian walk phase is compiled in when TRAFFIC_PED_EN is defined.
module traffic_ctrl_param #(
    parameter int NUM_DIR      = 2,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NUM_DIR-1:0] veh_req,
    input  logic               ped_req,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] red,
    output logic               walk,
    output logic [1:0]         active_dir
);

    // state     | meaning
    // ST_GREEN  | green lamp on approach dir
    // ST_YELLOW | yellow lamp on approach dir
    // ST_ALLRED | clearance, every approach red
    // ST_WALK   | every approach red, pedestrian walk lamp on
    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;
    localparam logic [1:0] ST_WALK   = 2'd3;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

    if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
        $error("traffic_ctrl_param: NUM_DIR must be 2..4");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       dir;
    logic [1:0]       dir_sel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur_last;
    logic             phase_end;
    logic             ped_pend;
    logic             found;
    logic             cur_req;

    always_comb begin
        case (state)
            ST_GREEN:  dur_last = GREEN_LAST;
            ST_YELLOW: dur_last = YELLOW_LAST;
            ST_ALLRED: dur_last = ALLRED_LAST;
            default:   dur_last = WALK_LAST;
        endcase
    end

    assign phase_end = tick && (cnt == dur_last);

    always_comb begin
        case (state)
            ST_GREEN:  state_nxt = ST_YELLOW;
            ST_YELLOW: state_nxt = ST_ALLRED;
            ST_ALLRED: state_nxt = ped_pend ? ST_WALK : ST_GREEN;
            default:   state_nxt = ST_GREEN;
        endcase
    end

    // Nearest requesting approach after dir; fall back to re-serving dir, then plain round robin.
    always_comb begin
        dir_sel = 2'((int'(dir) + 1) % NUM_DIR);
        found   = 1'b0;
        cur_req = 1'b0;
        for (int k = 1; k < NUM_DIR; k++) begin
            for (int i = 0; i < NUM_DIR; i++) begin
                if (!found && veh_req[i] && (i == (int'(dir) + k) % NUM_DIR)) begin
                    dir_sel = 2'(i);
                    found   = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_DIR; i++) begin
            if (i == int'(dir)) cur_req = veh_req[i];
        end
        if (!found && cur_req) dir_sel = dir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_GREEN;
            dir   <= 2'd0;
            cnt   <= '0;
        end else if (tick) begin
            if (phase_end) begin
                state <= state_nxt;
                cnt   <= '0;
                if (state_nxt == ST_GREEN) dir <= dir_sel;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef TRAFFIC_PED_EN
    logic enter_walk;

    assign enter_walk = phase_end && (state == ST_ALLRED) && ped_pend;

    // Clearing on WALK entry takes priority over a request arriving on that same edge.
    always_ff @(posedge clk) begin
        if (rst)             ped_pend <= 1'b0;
        else if (enter_walk) ped_pend <= 1'b0;
        else if (ped_req)    ped_pend <= 1'b1;
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
`endif

    always_comb begin
        green  = '0;
        yellow = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (i == int'(dir)) begin
                green[i]  = (state == ST_GREEN);
                yellow[i] = (state == ST_YELLOW);
            end
        end
    end

    assign red        = ~(green | yellow);
    assign walk       = (state == ST_WALK);
    assign active_dir = dir;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Table-driven bench for traffic_ctrl_param: a 2-approach instance runs vector tables,
// a 4-approach instance covers demand skipping with a hand-written sequence.
module tb_traffic_ctrl_param;

    localparam int PH_G = 0;
    localparam int PH_Y = 1;
    localparam int PH_A = 2;
    localparam int PH_W = 3;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [1:0] veh;
        logic       ped;
        logic [1:0] exp_green;
        logic [1:0] exp_yellow;
        logic [1:0] exp_red;
        logic       exp_walk;
        logic [1:0] exp_dir;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_req;
    logic [1:0] veh2;
    logic [3:0] veh4;
    logic [1:0] green2, yellow2, red2;
    logic       walk2;
    logic [1:0] dir2;
    logic [3:0] green4, yellow4, red4;
    logic       walk4;
    logic [1:0] dir4;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    traffic_ctrl_param u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .veh_req(veh2), .ped_req(ped_req),
        .green(green2), .yellow(yellow2), .red(red2), .walk(walk2), .active_dir(dir2)
    );

    traffic_ctrl_param #(.NUM_DIR(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick(tick), .veh_req(veh4), .ped_req(ped_req),
        .green(green4), .yellow(yellow4), .red(red4), .walk(walk4), .active_dir(dir4)
    );

    function automatic void add(input logic r, input logic t, input logic [1:0] v,
                                input logic p, input int ph, input int d);
        vec_t x;
        x.rst = r; x.tick = t; x.veh = v; x.ped = p;
        x.exp_green  = (ph == PH_G) ? 2'(1 << d) : 2'b00;
        x.exp_yellow = (ph == PH_Y) ? 2'(1 << d) : 2'b00;
        x.exp_red    = ~(x.exp_green | x.exp_yellow);
        x.exp_walk   = (ph == PH_W);
        x.exp_dir    = 2'(d);
        vecs.push_back(x);
    endfunction

    // Phase position within one 8-tick approach cycle with default durations, no walk.
    function automatic int free_ph(input int t);
        int p = t % 8;
        if (p <= 4) return PH_G;
        if (p <= 6) return PH_Y;
        return PH_A;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; veh2 = 2'b00; veh4 = 4'b0000;

        // Reset held two clocks
        add(1, 1, 2'b00, 0, PH_G, 0);
        add(1, 0, 2'b00, 1, PH_G, 0);
        // Free run, tick every cycle, no demand
        for (int t = 1; t <= 16; t++) add(0, 1, 2'b00, 0, free_ph(t), (t / 8) % 2);
        // Two ticks into green, then 50 idle clocks, then the remaining 3 ticks
        add(0, 1, 2'b00, 0, PH_G, 0);
        add(0, 1, 2'b00, 0, PH_G, 0);
        for (int i = 0; i < 50; i++) add(0, 0, 2'b00, 0, PH_G, 0);
        add(0, 1, 2'b00, 0, PH_G, 0);
        add(0, 0, 2'b00, 0, PH_G, 0);
        add(0, 1, 2'b00, 0, PH_G, 0);
        add(0, 1, 2'b00, 0, PH_Y, 0);
        // Reset raised mid-yellow
        add(1, 1, 2'b00, 0, PH_G, 0);
        // Demand only on approach 0: re-served after all-red
        for (int t = 1; t <= 8; t++) add(0, 1, 2'b01, 0, free_ph(t), 0);
        // Demand only on approach 1 from dir 0 then back: dir 1 served, then re-served
        add(1, 0, 2'b00, 0, PH_G, 0);
        for (int t = 1; t <= 16; t++) add(0, 1, 2'b10, 0, free_ph(t), (t >= 8) ? 1 : 0);
        add(1, 0, 2'b00, 0, PH_G, 0);
`ifdef TRAFFIC_PED_EN
        for (int t = 1; t <= 7; t++) add(0, 1, 2'b00, 0, free_ph(t), 0);
        vecs[$ - 5].ped = 1'b1;
        add(0, 1, 2'b00, 0, PH_W, 0);
        add(0, 1, 2'b00, 1, PH_W, 0);
        add(0, 1, 2'b00, 0, PH_W, 0);
        add(0, 1, 2'b00, 0, PH_G, 1);
        for (int t = 12; t <= 17; t++) add(0, 1, 2'b00, 0, (t <= 14) ? PH_G : (t <= 16) ? PH_Y : PH_A, 1);
        add(0, 1, 2'b00, 0, PH_W, 1);
        add(0, 1, 2'b00, 0, PH_W, 1);
        add(0, 1, 2'b00, 0, PH_W, 1);
        add(0, 1, 2'b00, 0, PH_G, 0);
`else
        for (int t = 1; t <= 16; t++) add(0, 1, 2'b00, (t % 2), free_ph(t), (t / 8) % 2);
`endif

        foreach (vecs[i]) begin
            rst = vecs[i].rst; tick = vecs[i].tick; veh2 = vecs[i].veh; ped_req = vecs[i].ped;
            step();
            chk("green",  i, 8'(green2),  8'(vecs[i].exp_green));
            chk("yellow", i, 8'(yellow2), 8'(vecs[i].exp_yellow));
            chk("red",    i, 8'(red2),    8'(vecs[i].exp_red));
            chk("walk",   i, 8'(walk2),   8'(vecs[i].exp_walk));
            chk("dir",    i, 8'(dir2),    8'(vecs[i].exp_dir));
            if (i == 19 + 25) chk("cnt_frozen", i, u_dut2.cnt, 8'd2);
        end

        // Four approaches, demand only on approach 3
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; veh4 = 4'b1000;
        step();
        chk("g4_reset", 0, 8'(green4), 8'h01);
        chk("r4_reset", 0, 8'(red4),   8'h0e);
        rst = 1'b0; tick = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            step();
            chk("g4_never_1_2", t, 8'(green4 & 4'b0110), 8'h00);
            if (t == 7) chk("r4_allred", t, 8'(red4), 8'h0f);
            if (t == 8 || t == 16 || t == 24) begin
                chk("g4_skip", t, 8'(green4), 8'h08);
                chk("d4_skip", t, 8'(dir4),   8'd3);
            end
        end
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
